soc_pwr_seq_csr: RTL
====================

Name: soc_pwr_seq_csr

Overview:
Parametrised successor to the SoC control CSR block. It is a memory-mapped register block that owns clock-enable, reset and PLL feedback-divider control for NUM_DOMAIN power domains (cores plus RAM), and adds a per-domain hardware power-up/power-down sequencer with PLL-lock timeout and fault reporting. It sits behind the SoC AXI-to-register bridge on the peripheral bus and drives the domain clock gates, resets and PLLs directly.

Parameters:
NUM_DOMAIN, 5, number of sequenced domains (cores + RAM); 1..16
FB_DIV_WIDTH, 8, PLL feedback divider width
FB_DIV_RESET, 8'd40, reset value of every FB_DIV register
CNT_W, 16, width of timeout/delay counters and of the TIMING fields
LOCK_TO_RESET, 1000, reset value of TIMING.lock_to (cycles)
RST_DLY_RESET, 16, reset value of TIMING.rst_dly (cycles)

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
reg_req_valid_i  in  1  register access request, single-cycle, no back-pressure
reg_req_write_i  in  1  1 = write, 0 = read
reg_req_addr_i  in  12  byte address relative to block base
reg_req_wdata_i  in  64  write data
reg_rsp_valid_o  out  1  response strobe, exactly one cycle after the request
reg_rsp_rdata_o  out  64  read data (0 on writes and errors)
reg_rsp_err_o  out  1  access error
dom_clk_en_o  out  NUM_DOMAIN  per-domain clock enable
dom_arst_o  out  NUM_DOMAIN  per-domain reset, active-high
dom_pll_fb_div_o  out  NUM_DOMAIN x FB_DIV_WIDTH  per-domain PLL feedback divider
dom_pll_locked_i  in  NUM_DOMAIN  PLL lock, asynchronous
irq_o  out  1  OR of all sticky fault bits

Behaviour:
- Reset values: dom_clk_en_o = 0, dom_arst_o = all 1, fb_div = FB_DIV_RESET, CTRL = 0, faults = 0, every FSM in OFF, rsp_valid = 0, irq_o = 0.
- Map, domain d at 0x20*d:
  - +0x00 CTRL RW: bit0 on_req; bit1 fault, W1C on write.
  - +0x08 FB_DIV RW.
  - +0x10 STATUS RO: [2:0] state, bit3 lock_sync, bit4 fault.
  - +0x18 reserved.
- Global TIMING at 0x20*NUM_DOMAIN, RW: [CNT_W-1:0] lock_to; [CNT_W+31:32] rst_dly.
- Access errors (err = 1, no state change, rdata = 0): addr[2:0] != 0, address out of range, reserved word, write to STATUS.
- Access latency: one request per cycle; response exactly one cycle later; writes take effect at the same edge that registers the response.
- FB_DIV write while the domain is not OFF: err = 1, value kept.
- dom_pll_locked_i passes through a 2-flop synchroniser (lock_sync).
- Per-domain FSM (encodings OFF 0, LOCK 1, CLK 2, RUN 3, DRAIN 4, FAULT 5); one shared-width counter per domain, cleared on every state entry:
  - OFF (clk_en 0, arst 1): on_req & !fault -> LOCK.
  - LOCK (clk_en 0, arst 1): !on_req -> OFF; else lock_sync -> CLK; else lock_to != 0 and counter == lock_to-1 -> FAULT. lock_to = 0 means no timeout.
  - CLK (clk_en 1, arst 1): lasts exactly rst_dly+1 cycles, then RUN. !lock_sync -> FAULT.
  - RUN (clk_en 1, arst 0): !on_req -> DRAIN; !lock_sync -> FAULT.
  - DRAIN (clk_en 1, arst 1): lasts rst_dly+1 cycles, then OFF. A new on_req is ignored until OFF.
  - FAULT (clk_en 0, arst 1): on entry, hardware sets fault and clears on_req. Stays in FAULT until fault is cleared by W1C, then -> OFF.
- Same-cycle collision: when a software write to on_req coincides with the hardware fault clear, hardware wins (on_req = 0).
- W1C of fault together with on_req = 1 in one write: fault is cleared and on_req = 1 is stored, so the next sequence starts from OFF.
- TIMING changes apply to counters already in progress from the next compare.
- Outputs are registered; no combinational path from req to outputs.

Optional Feature:
SOC_PWR_SEQ_THERMAL_TRIP_EN
- Defined:
  - Adds input dom_temp_i [NUM_DOMAIN x 10].
  - Adds RW register TRIP (address 0x20*NUM_DOMAIN+0x08) [9:0], reset 10'h3FF.
  - Adds CTRL bit2 trip, sticky, W1C.
  - A domain in RUN with dom_temp_i > TRIP sets trip and enters DRAIN with on_req cleared; irq_o also ORs the trip bits.
- Undefined: none of these exist; address 0x20*NUM_DOMAIN+0x08 returns err.

Test Plan:
- Reset -> dom_arst_o = 5'h1F, dom_clk_en_o = 0, dom_pll_fb_div_o[k] = 40, STATUS reads 0; FB_DIV 0x08 write 0x55, readback 0x55.
- Lock held high, rst_dly = 3, write CTRL d1 = 1 -> STATUS walks LOCK, CLK (4 cycles), RUN; dom_clk_en_o[1] rises before dom_arst_o[1] falls; exactly 4 cycles between them.
- Lock low, lock_to = 20, on_req d2 -> FAULT after 20 cycles in LOCK, irq_o = 1, CTRL d2 reads 0x2; write 0x2 -> OFF, irq_o = 0.
- d0 in RUN, drop dom_pll_locked_i[0] -> FAULT within 3 cycles, clk_en 0 and arst 1 in the same cycle; FB_DIV write during RUN -> err = 1, value unchanged.
- Reads at 0x003, 0x018, 0x800 and a write to STATUS -> err = 1, rdata = 0, no register changes.
- Assert arst_i while d3 is in CLK -> outputs at reset values immediately; after release, d3 stays OFF (on_req = 0).

Source files
------------

// File: rtl/soc_pwr_seq_csr.sv
// soc_pwr_seq_csr: memory-mapped clock/reset/PLL control for NUM_DOMAIN power
// domains, each with a hardware power-up/power-down sequencer and fault capture.
//
// Ports:
//   clk_i, arst_i                  system clock, async active-high reset
//   reg_req_* / reg_rsp_*          single-cycle register access, response one cycle later
//   dom_clk_en_o, dom_arst_o       per-domain clock enable and reset (active-high)
//   dom_pll_fb_div_o               per-domain PLL feedback divider
//   dom_pll_locked_i               per-domain PLL lock (asynchronous)
//   dom_temp_i                     per-domain temperature (SOC_PWR_SEQ_THERMAL_TRIP_EN only)
//   irq_o                          OR of sticky fault (and trip) bits
//
// Optional feature macro: SOC_PWR_SEQ_THERMAL_TRIP_EN adds the thermal trip register,
// the CTRL trip bit and the dom_temp_i input.
module soc_pwr_seq_csr #(
    parameter int unsigned                 NUM_DOMAIN    = 5,
    parameter int unsigned                 FB_DIV_WIDTH  = 8,
    parameter logic [FB_DIV_WIDTH-1:0]     FB_DIV_RESET  = 8'd40,
    parameter int unsigned                 CNT_W         = 16,
    parameter int unsigned                 LOCK_TO_RESET = 1000,
    parameter int unsigned                 RST_DLY_RESET = 16
) (
    input  logic                                   clk_i,
    input  logic                                   arst_i,
    input  logic                                   reg_req_valid_i,
    input  logic                                   reg_req_write_i,
    input  logic [11:0]                            reg_req_addr_i,
    input  logic [63:0]                            reg_req_wdata_i,
    output logic                                   reg_rsp_valid_o,
    output logic [63:0]                            reg_rsp_rdata_o,
    output logic                                   reg_rsp_err_o,
    output logic [NUM_DOMAIN-1:0]                  dom_clk_en_o,
    output logic [NUM_DOMAIN-1:0]                  dom_arst_o,
    output logic [NUM_DOMAIN-1:0][FB_DIV_WIDTH-1:0] dom_pll_fb_div_o,
    input  logic [NUM_DOMAIN-1:0]                  dom_pll_locked_i,
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
    input  logic [NUM_DOMAIN-1:0][9:0]             dom_temp_i,
`endif
    output logic                                   irq_o
);

    localparam int unsigned TIM_ADDR = 32 * NUM_DOMAIN;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LOCK  = 3'd1,
        S_CLK   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                  r_state     [NUM_DOMAIN];
    state_t                  w_state_nxt [NUM_DOMAIN];
    logic [CNT_W-1:0]        r_cnt       [NUM_DOMAIN];
    logic [CNT_W-1:0]        w_cnt_nxt   [NUM_DOMAIN];
    logic [FB_DIV_WIDTH-1:0] r_fb_div    [NUM_DOMAIN];

    logic [NUM_DOMAIN-1:0] r_on_req;
    logic [NUM_DOMAIN-1:0] r_fault;
    logic [NUM_DOMAIN-1:0] r_lock_meta;
    logic [NUM_DOMAIN-1:0] r_lock_sync;
    logic [NUM_DOMAIN-1:0] r_clk_en;
    logic [NUM_DOMAIN-1:0] r_arst;
    logic [NUM_DOMAIN-1:0] w_on_nxt;
    logic [NUM_DOMAIN-1:0] w_fault_nxt;
    logic [NUM_DOMAIN-1:0] w_clk_en_nxt;
    logic [NUM_DOMAIN-1:0] w_hit;
    logic [NUM_DOMAIN-1:0] w_ctrl_we;
    logic [NUM_DOMAIN-1:0] w_fb_we;

    logic [CNT_W-1:0] r_lock_to;
    logic [CNT_W-1:0] r_rst_dly;

    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [63:0] r_rsp_rdata;
    logic        r_irq;

    logic [31:0] w_addr32;
    logic [6:0]  w_dom_idx;
    logic [1:0]  w_word;
    logic        w_in_dom;
    logic        w_is_tim;
    logic        w_err;
    logic        w_we;
    logic        w_tim_we;
    logic        w_dom_off;
    logic [63:0] w_rdata;
    logic [63:0] w_ctrl_rd;
    logic [63:0] w_fb_rd;
    logic [63:0] w_st_rd;
    logic [63:0] w_tim_rd;
    logic        w_unused;

`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
    logic [9:0]            r_trip_thr;
    logic [NUM_DOMAIN-1:0] r_trip;
    logic [NUM_DOMAIN-1:0] w_trip_nxt;
    logic                  w_is_trip;
    logic                  w_trip_we;
`endif

    assign w_unused = ^reg_req_wdata_i;

    // Address decode, read mux and access-error detection.
    always_comb begin
        w_addr32  = {20'd0, reg_req_addr_i};
        w_dom_idx = reg_req_addr_i[11:5];
        w_word    = reg_req_addr_i[4:3];
        w_in_dom  = w_addr32 < TIM_ADDR;
        w_is_tim  = w_addr32 == TIM_ADDR;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
        w_is_trip = w_addr32 == TIM_ADDR + 32'd8;
`endif
        w_ctrl_rd = '0;
        w_fb_rd   = '0;
        w_st_rd   = '0;
        w_dom_off = 1'b0;
        for (int d = 0; d < NUM_DOMAIN; d++) begin
            w_hit[d] = w_in_dom && (w_dom_idx == 7'(d));
            if (w_hit[d]) begin
                w_ctrl_rd[0]   = r_on_req[d];
                w_ctrl_rd[1]   = r_fault[d];
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
                w_ctrl_rd[2]   = r_trip[d];
`endif
                w_fb_rd        = 64'(r_fb_div[d]);
                w_st_rd[2:0]   = r_state[d];
                w_st_rd[3]     = r_lock_sync[d];
                w_st_rd[4]     = r_fault[d];
                w_dom_off      = r_state[d] == S_OFF;
            end
        end
        w_tim_rd = '0;
        w_tim_rd[CNT_W-1:0]     = r_lock_to;
        w_tim_rd[CNT_W+31:32]   = r_rst_dly;

        w_err   = 1'b0;
        w_rdata = '0;
        if (reg_req_addr_i[2:0] != 3'd0) begin
            w_err = 1'b1;
        end else if (w_in_dom) begin
            unique case (w_word)
                2'd0: w_rdata = w_ctrl_rd;
                2'd1: begin
                    w_rdata = w_fb_rd;
                    if (reg_req_write_i && !w_dom_off) w_err = 1'b1;
                end
                2'd2: begin
                    w_rdata = w_st_rd;
                    if (reg_req_write_i) w_err = 1'b1;
                end
                default: w_err = 1'b1;
            endcase
        end else if (w_is_tim) begin
            w_rdata = w_tim_rd;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
        end else if (w_is_trip) begin
            w_rdata = {54'd0, r_trip_thr};
`endif
        end else begin
            w_err = 1'b1;
        end
        if (w_err || reg_req_write_i) w_rdata = '0;

        w_we      = reg_req_valid_i && reg_req_write_i && !w_err;
        w_ctrl_we = (w_we && w_word == 2'd0) ? w_hit : '0;
        w_fb_we   = (w_we && w_word == 2'd1) ? w_hit : '0;
        w_tim_we  = w_we && w_is_tim;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
        w_trip_we = w_we && w_is_trip;
`endif
    end

    // Per-domain sequencer next state and CTRL bit updates.
    always_comb begin
        for (int d = 0; d < NUM_DOMAIN; d++) begin
            w_state_nxt[d] = r_state[d];
            w_on_nxt[d]    = r_on_req[d];
            w_fault_nxt[d] = r_fault[d];
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
            w_trip_nxt[d]  = r_trip[d];
`endif
            unique case (r_state[d])
                S_OFF: begin
                    if (r_on_req[d] && !r_fault[d]) w_state_nxt[d] = S_LOCK;
                end
                S_LOCK: begin
                    if (!r_on_req[d])
                        w_state_nxt[d] = S_OFF;
                    else if (r_lock_sync[d])
                        w_state_nxt[d] = S_CLK;
                    else if (r_lock_to != '0 &&
                             r_cnt[d] >= r_lock_to - CNT_W'(1))
                        w_state_nxt[d] = S_FAULT;
                end
                S_CLK: begin
                    if (!r_lock_sync[d])
                        w_state_nxt[d] = S_FAULT;
                    else if (r_cnt[d] >= r_rst_dly)
                        w_state_nxt[d] = S_RUN;
                end
                S_RUN: begin
                    // Losing lock is a fault even if software is powering down.
                    if (!r_lock_sync[d])
                        w_state_nxt[d] = S_FAULT;
                    else if (!r_on_req[d])
                        w_state_nxt[d] = S_DRAIN;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
                    else if (dom_temp_i[d] > r_trip_thr) begin
                        w_state_nxt[d] = S_DRAIN;
                        w_trip_nxt[d]  = 1'b1;
                        w_on_nxt[d]    = 1'b0;
                    end
`endif
                end
                S_DRAIN: begin
                    if (r_cnt[d] >= r_rst_dly) w_state_nxt[d] = S_OFF;
                end
                S_FAULT: begin
                    if (!r_fault[d]) w_state_nxt[d] = S_OFF;
                end
                default: w_state_nxt[d] = S_OFF;
            endcase

            if (w_ctrl_we[d]) begin
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
                if (!w_trip_nxt[d] || r_state[d] != S_RUN ||
                    w_state_nxt[d] != S_DRAIN)
                    w_on_nxt[d] = reg_req_wdata_i[0];
                if (reg_req_wdata_i[2] && w_trip_nxt[d] == r_trip[d])
                    w_trip_nxt[d] = 1'b0;
`else
                w_on_nxt[d] = reg_req_wdata_i[0];
`endif
                if (reg_req_wdata_i[1]) w_fault_nxt[d] = 1'b0;
            end

            // Fault entry overrides any same-cycle software write.
            if (w_state_nxt[d] == S_FAULT && r_state[d] != S_FAULT) begin
                w_fault_nxt[d] = 1'b1;
                w_on_nxt[d]    = 1'b0;
            end

            if (w_state_nxt[d] != r_state[d])
                w_cnt_nxt[d] = '0;
            else if (r_state[d] inside {S_LOCK, S_CLK, S_DRAIN})
                w_cnt_nxt[d] = r_cnt[d] + CNT_W'(1);
            else
                w_cnt_nxt[d] = '0;

            w_clk_en_nxt[d] = w_state_nxt[d] inside {S_CLK, S_RUN, S_DRAIN};
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int d = 0; d < NUM_DOMAIN; d++) begin
                r_state[d]  <= S_OFF;
                r_cnt[d]    <= '0;
                r_fb_div[d] <= FB_DIV_RESET;
            end
            r_on_req    <= '0;
            r_fault     <= '0;
            r_lock_meta <= '0;
            r_lock_sync <= '0;
            r_clk_en    <= '0;
            r_arst      <= '1;
            r_lock_to   <= CNT_W'(LOCK_TO_RESET);
            r_rst_dly   <= CNT_W'(RST_DLY_RESET);
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_irq       <= 1'b0;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
            r_trip_thr  <= 10'h3FF;
            r_trip      <= '0;
`endif
        end else begin
            for (int d = 0; d < NUM_DOMAIN; d++) begin
                r_state[d] <= w_state_nxt[d];
                r_cnt[d]   <= w_cnt_nxt[d];
                r_arst[d]  <= w_state_nxt[d] != S_RUN;
                if (w_fb_we[d])
                    r_fb_div[d] <= reg_req_wdata_i[FB_DIV_WIDTH-1:0];
            end
            r_on_req    <= w_on_nxt;
            r_fault     <= w_fault_nxt;
            r_clk_en    <= w_clk_en_nxt;
            r_lock_meta <= dom_pll_locked_i;
            r_lock_sync <= r_lock_meta;
            if (w_tim_we) begin
                r_lock_to <= reg_req_wdata_i[CNT_W-1:0];
                r_rst_dly <= reg_req_wdata_i[CNT_W+31:32];
            end
            r_rsp_valid <= reg_req_valid_i;
            r_rsp_err   <= reg_req_valid_i && w_err;
            r_rsp_rdata <= reg_req_valid_i ? w_rdata : '0;
`ifdef SOC_PWR_SEQ_THERMAL_TRIP_EN
            if (w_trip_we) r_trip_thr <= reg_req_wdata_i[9:0];
            r_trip      <= w_trip_nxt;
            r_irq       <= (|w_fault_nxt) || (|w_trip_nxt);
`else
            r_irq       <= |w_fault_nxt;
`endif
        end
    end

    always_comb begin
        for (int d = 0; d < NUM_DOMAIN; d++) begin
            dom_pll_fb_div_o[d] = r_fb_div[d];
        end
    end

    assign dom_clk_en_o    = r_clk_en;
    assign dom_arst_o      = r_arst;
    assign reg_rsp_valid_o = r_rsp_valid;
    assign reg_rsp_err_o   = r_rsp_err;
    assign reg_rsp_rdata_o = r_rsp_rdata;
    assign irq_o           = r_irq;

endmodule
